// File: rtl/syscall_print_unit.sv
// syscall_print_unit
//   Services the MIPS print_string (v0=4), print_char (v0=11) and exit (v0=10)
//   syscalls decoded in ID. While servicing, it freezes the front of the
//   pipeline, walks a NUL-terminated string in data memory one word at a time,
//   and hands it to the console sink one character per valid/ready handshake.
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_syscall_valid         syscall present in ID
//   i_v0, i_a0              service code and argument (string address / char)
//   o_stall                 freeze PC, IF/ID and ID/EX
//   o_mem_rd_en, o_mem_addr word-aligned data-memory read request
//   i_mem_rd_data           read word, valid the cycle after o_mem_rd_en
//   o_char_valid/o_char_data/i_char_ready   character stream to the sink
//   o_done                  one-cycle pulse at service completion
//   o_exit_req              sticky exit request
//   o_trunc_err             sticky: string reached MAX_LEN without a NUL
module syscall_print_unit #(
  parameter int MAX_LEN = 256,
  parameter int CHAR_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_syscall_valid,
  input  logic [31:0]       i_v0,
  input  logic [31:0]       i_a0,
  output logic              o_stall,
  output logic              o_mem_rd_en,
  output logic [31:0]       o_mem_addr,
  input  logic [31:0]       i_mem_rd_data,
  output logic              o_char_valid,
  output logic [CHAR_W-1:0] o_char_data,
  input  logic              i_char_ready,
  output logic              o_done,
  output logic              o_exit_req,
  output logic              o_trunc_err
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state;
  logic [31:0]       r_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_word;
  logic [CHAR_W-1:0] r_chr;
  logic              r_is_str;
  logic              r_exit;
  logic              r_trunc;

  logic              w_is_str_req;
  logic              w_is_chr_req;
  logic              w_is_exit_req;
  logic              w_req_ok;
  logic [7:0]        w_byte;
  logic [31:0]       w_ptr_nxt;
  logic              w_at_max;

  assign w_is_str_req  = (i_v0 == 32'd4);
  assign w_is_chr_req  = (i_v0 == 32'd11);
  assign w_is_exit_req = (i_v0 == 32'd10);
  assign w_req_ok      = i_syscall_valid & (w_is_str_req | w_is_chr_req | w_is_exit_req);

  // Little-endian lane select within the buffered word.
  assign w_byte    = r_word[{r_ptr[1:0], 3'b000} +: 8];
  assign w_ptr_nxt = r_ptr + 32'd1;
  assign w_at_max  = (r_count == CNT_W'(MAX_LEN));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_count  <= '0;
      r_word   <= '0;
      r_chr    <= '0;
      r_is_str <= 1'b0;
      r_exit   <= 1'b0;
      r_trunc  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_ok) begin
            if (w_is_str_req) begin
              r_ptr    <= i_a0;
              r_count  <= '0;
              r_is_str <= 1'b1;
              r_state  <= S_FETCH;
            end else if (w_is_chr_req) begin
              r_chr    <= CHAR_W'(i_a0[7:0]);
              r_is_str <= 1'b0;
              r_state  <= S_EMIT;
            end else begin
              r_exit   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_word  <= i_mem_rd_data;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          // NUL wins over the length limit: a string of exactly MAX_LEN
          // characters followed by NUL is not a truncation.
          if (w_byte == 8'h00) begin
            r_state <= S_DONE;
          end else if (w_at_max) begin
            r_trunc <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_chr   <= CHAR_W'(w_byte);
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (i_char_ready) begin
            if (!r_is_str) begin
              r_state <= S_DONE;
            end else begin
              r_ptr <= w_ptr_nxt;
              if (!w_at_max) r_count <= r_count + 1'b1;
              // Crossing into a new word needs a refetch.
              r_state <= (w_ptr_nxt[1:0] == 2'b00) ? S_FETCH : S_SCAN;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stall      = (r_state == S_FETCH) | (r_state == S_LOAD) | (r_state == S_SCAN) |
                        (r_state == S_EMIT)  | ((r_state == S_IDLE) & w_req_ok);
  assign o_mem_rd_en  = (r_state == S_FETCH);
  assign o_mem_addr   = (r_state == S_FETCH) ? {r_ptr[31:2], 2'b00} : 32'd0;
  assign o_char_valid = (r_state == S_EMIT);
  assign o_char_data  = (r_state == S_EMIT) ? r_chr : '0;
  assign o_done       = (r_state == S_DONE);
  assign o_exit_req   = r_exit;
  assign o_trunc_err  = r_trunc;

endmodule

// File: tb/tb_syscall_print_unit.sv
// Directed bench for syscall_print_unit. MAX_LEN is set to 5 so that a
// 5-character string exercises the NUL-at-limit boundary and an 8-byte
// unterminated string exercises truncation.
module tb_syscall_print_unit;

  localparam int ML = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        syscall_valid = 1'b0;
  logic [31:0] v0 = '0, a0 = '0;
  logic        stall, mem_rd_en, char_valid, done, exit_req, trunc_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic [7:0]  char_data;
  logic        char_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];
  logic [7:0]  chq[$];
  logic [31:0] rdq[$];
  int          done_cnt = 0;

  syscall_print_unit #(.MAX_LEN(ML), .CHAR_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_syscall_valid(syscall_valid),
    .i_v0(v0), .i_a0(a0), .o_stall(stall), .o_mem_rd_en(mem_rd_en),
    .o_mem_addr(mem_addr), .i_mem_rd_data(mem_rd_data),
    .o_char_valid(char_valid), .o_char_data(char_data),
    .i_char_ready(char_ready), .o_done(done), .o_exit_req(exit_req),
    .o_trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  // Registered data memory: word returned the cycle after the request.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[11:2]];

  always @(negedge clk) begin
    if (rst_n) begin
      if (char_valid && char_ready) chq.push_back(char_data);
      if (mem_rd_en) rdq.push_back(mem_addr);
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns stall as seen in the accept cycle.
  task automatic issue(input logic [31:0] code, input logic [31:0] arg, output logic acc_stall);
    @(posedge clk); #1;
    syscall_valid = 1'b1; v0 = code; a0 = arg;
    @(negedge clk);
    acc_stall = stall;
    @(posedge clk); #1;
    syscall_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int drops);
    int got;
    got = 0; drops = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      if (!stall) drops++;
    end
    chk(tag, got, 1);
  endtask

  task automatic clr();
    chq.delete(); rdq.delete(); done_cnt = 0;
  endtask

  initial begin
    logic s;
    int   drops;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[32'h100 >> 2] = 32'h006C6548;   // "Hel\0"
    mem[32'h200 >> 2] = 32'h44434241;   // "ABCD"
    mem[32'h204 >> 2] = 32'h00000045;   // "E\0"
    mem[32'h300 >> 2] = 32'h5A7A7978;   // "xyzZ"
    mem[32'h304 >> 2] = 32'h00000000;
    mem[32'h400 >> 2] = 32'h64636261;   // "abcd"
    mem[32'h404 >> 2] = 32'h68676665;   // "efgh", no NUL

    // Reset state
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_flags", {exit_req, trunc_err}, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: "Hel"
    clr();
    issue(32'd4, 32'h100, s);
    chk("t1_acc_stall", s, 1);
    wait_done("t1_done", 100, drops);
    chk("t1_stall_held", drops, 0);
    chk("t1_nchars", chq.size(), 3);
    if (chq.size() == 3) chk("t1_chars", {chq[0], chq[1], chq[2]}, 24'h48656C);
    chk("t1_nreads", rdq.size(), 1);
    @(negedge clk);
    chk("t1_done_pulse", done_cnt, 1);
    chk("t1_stall_after", stall, 0);

    // 2: "ABCDE" -- exactly MAX_LEN chars then NUL, two word reads
    clr();
    issue(32'd4, 32'h200, s);
    wait_done("t2_done", 100, drops);
    chk("t2_nreads", rdq.size(), 2);
    if (rdq.size() == 2) begin
      chk("t2_rd0", rdq[0], 32'h200);
      chk("t2_rd1", rdq[1], 32'h204);
    end
    chk("t2_nchars", chq.size(), 5);
    if (chq.size() == 5) chk("t2_chars", {chq[0], chq[1], chq[2], chq[3], chq[4]}, 40'h4142434445);
    chk("t2_no_trunc", trunc_err, 0);

    // 3: print_char with sink back-pressure
    clr();
    char_ready = 1'b0;
    issue(32'd11, 32'h0000_0A5A, s);
    chk("t3_acc_stall", s, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", char_valid, 1);
      chk("t3_hold_data", char_data, 8'h5A);
      chk("t3_hold_stall", stall, 1);
    end
    @(posedge clk); #1; char_ready = 1'b1;
    @(negedge clk);
    chk("t3_hs_valid", char_valid, 1);
    chk("t3_hs_done", done, 0);
    @(negedge clk);
    chk("t3_done", done, 1);
    chk("t3_valid_off", char_valid, 0);
    chk("t3_nchars", chq.size(), 1);

    // 4: exit
    clr();
    issue(32'd10, 32'h0, s);
    chk("t4_acc_stall", s, 1);
    @(negedge clk);
    chk("t4_exit", exit_req, 1);
    chk("t4_done", done, 1);
    chk("t4_stall", stall, 0);
    @(negedge clk);
    chk("t4_done_once", done, 0);
    chk("t4_exit_sticky", exit_req, 1);
    chk("t4_nchars", chq.size(), 0);

    // Unrecognised code: ignored
    clr();
    issue(32'd5, 32'h100, s);
    chk("bad_no_stall", s, 0);
    repeat (3) @(negedge clk);
    chk("bad_no_done", done_cnt, 0);

    // 5: unaligned start at lane 3
    clr();
    issue(32'd4, 32'h303, s);
    wait_done("t5_done", 100, drops);
    chk("t5_nchars", chq.size(), 1);
    if (chq.size() == 1) chk("t5_char", chq[0], 8'h5A);
    chk("t5_nreads", rdq.size(), 2);
    if (rdq.size() == 2) begin
      chk("t5_rd0", rdq[0], 32'h300);
      chk("t5_rd1", rdq[1], 32'h304);
    end

    // 6: truncation at MAX_LEN
    clr();
    issue(32'd4, 32'h400, s);
    wait_done("t6_done", 100, drops);
    chk("t6_nchars", chq.size(), ML);
    if (chq.size() == ML) chk("t6_chars", {chq[0], chq[1], chq[2], chq[3], chq[4]}, 40'h6162636465);
    chk("t6_trunc", trunc_err, 1);

    // Reset mid-EMIT
    clr();
    char_ready = 1'b0;
    issue(32'd4, 32'h400, s);
    drops = 0;
    for (int i = 0; i < 20 && !char_valid; i++) @(negedge clk);
    chk("t6_in_emit", char_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", char_valid, 0);
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_data", char_data, 0);
    chk("t6_rst_flags", {exit_req, trunc_err, done, mem_rd_en}, 0);
    @(negedge clk); rst_n = 1'b1; char_ready = 1'b1;
    @(negedge clk);
    chk("t6_post_idle", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
